// File: rtl/exbus_pkg.sv
// Shared definitions for the exbus word stream: word width, special-word code, grant states.
package exbus_pkg;

    localparam int         EXWORD_W     = 35;
    localparam logic [1:0] SPECIAL_CODE = 2'b11;

    // Encoding doubles as the one-hot {B,A} grant vector.
    typedef enum logic [1:0] {
        GNT_IDLE = 2'b00,
        GNT_A    = 2'b01,
        GNT_B    = 2'b10
    } gnt_state_e;

endpackage

// File: rtl/exarbiter.sv
// Packet arbiter merging channels A and B into one registered stream, 1-cycle latency, busy-based flow control.
// Round-robin in IDLE by default; defining EXARB_FIXED_PRIORITY_EN makes A always win contention.
module exarbiter
    import exbus_pkg::*;
#(
    parameter logic OPT_LOWPOWER = 1'b0,
    parameter int   LGSTALL      = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stb_a,
    input  logic [EXWORD_W-1:0] i_word_a,
    input  logic                i_last_a,
    output logic                o_busy_a,
    input  logic                i_stb_b,
    input  logic [EXWORD_W-1:0] i_word_b,
    input  logic                i_last_b,
    output logic                o_busy_b,
    output logic                o_stb,
    output logic [EXWORD_W-1:0] o_word,
    output logic                o_last,
    input  logic                i_busy,
    output logic [1:0]          o_grant,
    output logic                o_stall_err
);

    localparam logic [LGSTALL-1:0] STALL_MAX = '1;

    gnt_state_e         state_q, state_d;
    logic               pref_b_q, pref_b_d;
    logic [LGSTALL-1:0] stall_q, stall_d, stall_inc;
    logic               stall_err_q, stall_err_d;
    logic               pick_b, gnt_a, gnt_b, out_free, xfer_a, xfer_b;
    logic               own_stb, own_xfer, own_last;
    logic               o_stb_q, o_last_q;
    logic [EXWORD_W-1:0] o_word_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= GNT_IDLE;
            pref_b_q    <= 1'b0;
            stall_q     <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pref_b_q    <= pref_b_d;
            stall_q     <= stall_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Grant is combinational in IDLE so the first word of a packet is accepted immediately.
    always_comb begin
`ifdef EXARB_FIXED_PRIORITY_EN
        pick_b   = i_stb_b && !i_stb_a;
`else
        pick_b   = i_stb_b && (!i_stb_a || pref_b_q);
`endif
        gnt_a    = (state_q == GNT_A) || ((state_q == GNT_IDLE) && i_stb_a && !pick_b);
        gnt_b    = (state_q == GNT_B) || ((state_q == GNT_IDLE) && pick_b);
        out_free = !o_stb_q || !i_busy;
        o_busy_a = i_reset || !(gnt_a && out_free);
        o_busy_b = i_reset || !(gnt_b && out_free);
        xfer_a   = i_stb_a && !o_busy_a;
        xfer_b   = i_stb_b && !o_busy_b;
        own_stb  = (state_q == GNT_B) ? i_stb_b : i_stb_a;
        own_xfer = (state_q == GNT_B) ? xfer_b  : xfer_a;
        own_last = (state_q == GNT_B) ? i_last_b : i_last_a;
    end

    assign stall_inc = (stall_q == STALL_MAX) ? STALL_MAX : stall_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        pref_b_d    = pref_b_q;
        stall_d     = stall_q;
        stall_err_d = 1'b0;
        case (state_q)
            GNT_IDLE: begin
                stall_d = '0;
                if (gnt_a) begin
                    if (xfer_a && i_last_a) pref_b_d = 1'b1;
                    else                    state_d  = GNT_A;
                end else if (gnt_b) begin
                    if (xfer_b && i_last_b) pref_b_d = 1'b0;
                    else                    state_d  = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (own_xfer) begin
                    stall_d = '0;
                    if (own_last) begin
                        state_d  = GNT_IDLE;
                        pref_b_d = (state_q == GNT_A);
                    end
                end else if (!own_stb) begin
                    // A stalled source is abandoned mid-packet; the other side gets the next turn.
                    stall_d = stall_inc;
                    if (stall_inc == STALL_MAX) begin
                        stall_err_d = 1'b1;
                        state_d     = GNT_IDLE;
                        pref_b_d    = (state_q == GNT_A);
                    end
                end
            end
            default: state_d = GNT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stb_q  <= 1'b0;
            o_last_q <= 1'b0;
            o_word_q <= '0;
        end else if (out_free) begin
            o_stb_q  <= xfer_a || xfer_b;
            o_last_q <= xfer_b ? i_last_b : (xfer_a && i_last_a);
            if (xfer_b)            o_word_q <= i_word_b;
            else if (xfer_a)       o_word_q <= i_word_a;
            else if (OPT_LOWPOWER) o_word_q <= '0;
        end
    end

    assign o_stb       = o_stb_q;
    assign o_word      = o_word_q;
    assign o_last      = o_last_q;
    assign o_grant     = state_q;
    assign o_stall_err = stall_err_q;

endmodule

// File: tb/tb_exarbiter.sv
// Directed and randomized bench for exarbiter against a packet-level reference model.
module tb_exarbiter;
    import exbus_pkg::*;

    logic                i_clk = 1'b0;
    logic                i_reset, i_stb_a, i_last_a, i_stb_b, i_last_b, i_busy;
    logic [EXWORD_W-1:0] i_word_a, i_word_b, o_word;
    logic                o_busy_a, o_busy_b, o_stb, o_last, o_stall_err;
    logic [1:0]          o_grant;

    int errs = 0, checks = 0;

    // Reference model state: words still to send, accepted words awaiting output, packet owner.
    logic [35:0] qa[$], qb[$], exp_q[$];
    int          owner;
    bit          pref_b, held;
    logic [35:0] held_w;
    int          starts[$];

    exarbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_stb_a(i_stb_a), .i_word_a(i_word_a), .i_last_a(i_last_a), .o_busy_a(o_busy_a),
        .i_stb_b(i_stb_b), .i_word_b(i_word_b), .i_last_b(i_last_b), .o_busy_b(o_busy_b),
        .o_stb(o_stb), .o_word(o_word), .o_last(o_last), .i_busy(i_busy),
        .o_grant(o_grant), .o_stall_err(o_stall_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); exp_q.delete(); starts.delete();
        owner = -1; pref_b = 1'b0; held = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_stb_a = 1'b0; i_stb_b = 1'b0; i_last_a = 1'b0; i_last_b = 1'b0;
        i_busy  = 1'b0; i_word_a = '0; i_word_b = '0;
        tick();
        i_reset = 1'b0;
        model_reset();
    endtask

    // Called at the falling edge with the handshakes that will complete on the next rising edge.
    task automatic model_check(input bit xa, input bit xb);
        if (held) chk("out_hold", {o_stb, o_last, o_word}, {1'b1, held_w});
        held   = o_stb && i_busy;
        held_w = {o_last, o_word};
        if (o_stb && !i_busy) begin
            if (exp_q.size() == 0) chk("out_spurious", o_stb, 1'b0);
            else                   chk("out_word", {o_last, o_word}, exp_q.pop_front());
        end
        if (owner < 0 && (i_stb_a || i_stb_b)) begin
`ifdef EXARB_FIXED_PRIORITY_EN
            owner = i_stb_a ? 0 : 1;
`else
            owner = (i_stb_a && i_stb_b) ? (pref_b ? 1 : 0) : (i_stb_b ? 1 : 0);
`endif
            starts.push_back(owner);
        end
        if (owner == 0) chk("nonowner_busy_b", o_busy_b, 1'b1);
        if (owner == 1) chk("nonowner_busy_a", o_busy_a, 1'b1);
        if (xa) begin
            chk("xfer_owner_a", owner, 0);
            exp_q.push_back({i_last_a, i_word_a});
            if (i_last_a) begin owner = -1; pref_b = 1'b1; end
        end
        if (xb) begin
            chk("xfer_owner_b", owner, 1);
            exp_q.push_back({i_last_b, i_word_b});
            if (i_last_b) begin owner = -1; pref_b = 1'b0; end
        end
    endtask

    task automatic run_traffic(input int max_cycles, input bit rnd);
        int cyc = 0;
        bit xa, xb;
        held = 1'b0;
        while ((qa.size() > 0 || qb.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            if (!i_stb_a && qa.size() > 0 && (!rnd || $urandom_range(3) != 0)) i_stb_a = 1'b1;
            if (!i_stb_b && qb.size() > 0 && (!rnd || $urandom_range(3) != 0)) i_stb_b = 1'b1;
            if (i_stb_a) begin i_word_a = qa[0][34:0]; i_last_a = qa[0][35]; end
            if (i_stb_b) begin i_word_b = qb[0][34:0]; i_last_b = qb[0][35]; end
            i_busy = rnd ? ($urandom_range(9) < 3) : 1'b0;
            @(negedge i_clk);
            xa = i_stb_a && !o_busy_a;
            xb = i_stb_b && !o_busy_b;
            model_check(xa, xb);
            tick();
            if (xa) begin void'(qa.pop_front()); i_stb_a = 1'b0; i_last_a = 1'b0; end
            if (xb) begin void'(qb.pop_front()); i_stb_b = 1'b0; i_last_b = 1'b0; end
            cyc++;
        end
        i_busy = 1'b0;
        chk("traffic_pending", qa.size() + qb.size() + exp_q.size(), 0);
    endtask

    task automatic gen_packets(input int n, input bit chan_b);
        logic [34:0] w;
        int len;
        for (int p = 0; p < n; p++) begin
            len = $urandom_range(4, 1);
            for (int k = 0; k < len; k++) begin
                w[34:33] = 2'($urandom_range(3));
                w[32]    = 1'($urandom_range(1));
                w[31:0]  = $urandom();
                if (chan_b) qb.push_back({(k == len - 1), w});
                else        qa.push_back({(k == len - 1), w});
            end
        end
    endtask

    initial begin
        int n;
        bit found;
        i_reset = 1'b1;
        i_stb_a = 1'b0; i_stb_b = 1'b0; i_last_a = 1'b0; i_last_b = 1'b0;
        i_busy  = 1'b0; i_word_a = 35'h7_1234_5678; i_word_b = 35'h0_5555_5555;
        i_stb_a = 1'b1;
        @(negedge i_clk);
        chk("rst_stb", o_stb, 1'b0);
        chk("rst_word", o_word, 35'h0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_stall_err", o_stall_err, 1'b0);
        chk("rst_busy_a", o_busy_a, 1'b1);
        chk("rst_busy_b", o_busy_b, 1'b1);
        do_reset();

        // Three-word packet on A with a free downstream.
        i_stb_a = 1'b1; i_word_a = 35'h1; i_last_a = 1'b0;
        @(negedge i_clk);
        chk("r32_busy_a0", o_busy_a, 1'b0);
        chk("r32_stb0", o_stb, 1'b0);
        tick(); i_word_a = 35'h2;
        @(negedge i_clk);
        chk("r32_w1", {o_stb, o_last, o_word}, {2'b10, 35'h1});
        chk("r32_grant1", o_grant, 2'b01);
        tick(); i_word_a = 35'h3; i_last_a = 1'b1;
        @(negedge i_clk);
        chk("r32_w2", {o_stb, o_last, o_word}, {2'b10, 35'h2});
        chk("r32_grant2", o_grant, 2'b01);
        tick(); i_stb_a = 1'b0; i_last_a = 1'b0;
        @(negedge i_clk);
        chk("r32_w3", {o_stb, o_last, o_word}, {2'b11, 35'h3});
        tick();
        @(negedge i_clk);
        chk("r32_stb_drop", o_stb, 1'b0);
        chk("r32_grant_idle", o_grant, 2'b00);
        tick();

        // Contention from reset, then a lone A packet, then contention again.
        do_reset();
        qa.push_back({1'b0, 35'h0A1}); qa.push_back({1'b1, 35'h0A2});
        qb.push_back({1'b0, 35'h0B1}); qb.push_back({1'b1, 35'h0B2});
        run_traffic(50, 1'b0);
        chk("r33_first_a", starts.size() > 0 ? starts[0] : -1, 0);
        chk("r33_then_b", starts.size() > 1 ? starts[1] : -1, 1);
        starts.delete();
        qa.push_back({1'b1, 35'h0A3});
        run_traffic(20, 1'b0);
        starts.delete();
        qa.push_back({1'b0, 35'h0A4}); qa.push_back({1'b1, 35'h0A5});
        qb.push_back({1'b0, 35'h0B4}); qb.push_back({1'b1, 35'h0B5});
        run_traffic(50, 1'b0);
`ifdef EXARB_FIXED_PRIORITY_EN
        chk("r33_repeat_first", starts.size() > 0 ? starts[0] : -1, 0);
`else
        chk("r33_repeat_first", starts.size() > 0 ? starts[0] : -1, 1);
`endif

        // Downstream stall for five cycles mid-packet.
        i_stb_a = 1'b1; i_word_a = 35'h11; i_last_a = 1'b0;
        tick(); i_word_a = 35'h12; i_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("r34_hold_word", {o_stb, o_word}, {1'b1, 35'h11});
            chk("r34_busy_a", o_busy_a, 1'b1);
            tick();
        end
        i_busy = 1'b0;
        @(negedge i_clk);
        chk("r34_release", {o_busy_a, o_word}, {1'b0, 35'h11});
        tick(); i_word_a = 35'h13; i_last_a = 1'b1;
        @(negedge i_clk);
        chk("r34_w2", o_word, 35'h12);
        tick(); i_stb_a = 1'b0; i_last_a = 1'b0;
        @(negedge i_clk);
        chk("r34_w3", {o_stb, o_last, o_word}, {2'b11, 35'h13});
        tick();
        @(negedge i_clk);
        chk("r34_no_dup", o_stb, 1'b0);
        tick();

        // Owner A goes silent mid-packet while B waits.
        i_stb_a = 1'b1; i_word_a = 35'h21; i_last_a = 1'b0;
        tick();
        i_stb_a = 1'b0; i_stb_b = 1'b1; i_word_b = 35'h31; i_last_b = 1'b0;
        n = 0; found = 1'b0;
        while (!found && n < 300) begin
            @(negedge i_clk);
            n++;
            if (n == 128) chk("r35_b_blocked", o_busy_b, 1'b1);
            if (o_stall_err) found = 1'b1;
            else tick();
        end
        chk("r35_timeout_cycle", n, 256);
        chk("r35_b_granted", o_busy_b, 1'b0);
        tick(); i_word_b = 35'h32; i_last_b = 1'b1;
        @(negedge i_clk);
        chk("r35_single_pulse", o_stall_err, 1'b0);
        chk("r35_grant_b", o_grant, 2'b10);
        chk("r35_b_w1", o_word, 35'h31);
        tick(); i_stb_b = 1'b0; i_last_b = 1'b0;
        @(negedge i_clk);
        chk("r35_b_w2", {o_last, o_word}, {1'b1, 35'h32});
        tick();

        // Special word passes untouched.
        i_stb_b = 1'b1; i_word_b = 35'h6_0000_0000; i_last_b = 1'b1;
        tick(); i_stb_b = 1'b0; i_last_b = 1'b0;
        @(negedge i_clk);
        chk("r36_special", {o_stb, o_last, o_word}, {2'b11, 35'h6_0000_0000});
        tick();

        // Reset in the middle of a B packet.
        i_stb_b = 1'b1; i_word_b = 35'h41; i_last_b = 1'b0;
        tick(); i_word_b = 35'h42;
        tick(); i_word_b = 35'h43; i_last_b = 1'b1;
        #2 i_reset = 1'b1;
        #1;
        chk("r37_outputs", {o_stb, o_last, o_word, o_grant}, '0);
        chk("r37_busy", {o_busy_a, o_busy_b}, 2'b11);
        i_stb_b = 1'b0; i_last_b = 1'b0;
        tick(); i_reset = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            chk("r37_no_residual", o_stb, 1'b0);
            tick();
        end
        qa.push_back({1'b0, 35'h51}); qa.push_back({1'b1, 35'h52});
        run_traffic(30, 1'b0);

        // Randomized traffic with gaps and downstream backpressure.
        do_reset();
        gen_packets(30, 1'b0);
        gen_packets(30, 1'b1);
        run_traffic(5000, 1'b1);
        chk("rand_all_packets", starts.size(), 60);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/exarbiter.md
EXARBITER -- requirements
Module: exarbiter

Interface
REQ-001 Parameter OPT_LOWPOWER, 1'b0, when set o_word SHALL be forced to zero whenever o_stb is low.
REQ-002 Parameter LGSTALL, 8, log2 of the mid-packet stall limit in cycles.
REQ-003 i_clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_stb_a, i_word_a[34:0], i_last_a  input  1/35/1  channel A (bus responses) word, valid, end-of-packet.
REQ-006 o_busy_a  output  1  channel A backpressure.
REQ-007 i_stb_b, i_word_b[34:0], i_last_b  input  1/35/1  channel B (console/stream) word, valid, end-of-packet.
REQ-008 o_busy_b  output  1  channel B backpressure.
REQ-009 o_stb, o_word[34:0], o_last  output  1/35/1  merged word stream to the idle inserter.
REQ-010 i_busy  input  1  downstream backpressure.
REQ-011 o_grant[1:0]  output  2  one-hot current owner {B,A}; 0 when idle.
REQ-012 o_stall_err  output  1  one-cycle pulse on a mid-packet stall timeout.

Function
REQ-013 Input word SHALL transfer when i_stb_x && !o_busy_x; output word SHALL transfer when o_stb && !i_busy.
REQ-014 States: IDLE, OWN_A, OWN_B; o_grant SHALL equal 2'b00, 2'b01, 2'b10 respectively.
REQ-015 IDLE->OWN_x SHALL occur in the cycle a request is seen, combinationally granting so the first word transfers with zero added latency.
REQ-016 When both request in IDLE, the channel not served by the last completed packet SHALL win (round-robin); after reset A SHALL be preferred.
REQ-017 OWN_x SHALL persist until a word with i_last_x transfers, then return to IDLE; packets SHALL never interleave.
REQ-018 o_busy_x SHALL be high unless x owns (or is being granted) and (!o_stb || !i_busy).
REQ-019 Non-owner busy SHALL be high regardless of downstream state.
REQ-020 Output register: one-cycle latency input-to-o_stb; o_word/o_last SHALL hold stable while o_stb && i_busy.
REQ-021 o_stb SHALL drop on the cycle after its last transfer when no new word enters.
REQ-022 Words with o_word[34:33]==2'b11 SHALL pass unmodified; arbiter never generates words.
REQ-023 Stall counter (LGSTALL bits) SHALL count cycles in OWN_x with !i_stb_x, clear on any owner transfer, saturate at all-ones.
REQ-024 On reaching all-ones, arbiter SHALL pulse o_stall_err, return to IDLE and give preference to the other channel; the truncated packet is not terminated.
REQ-025 Downstream stall (i_busy) SHALL NOT advance the stall counter.

Reset
REQ-026 Asynchronous assertion SHALL force IDLE, o_stb=0, o_word=0, o_last=0, o_grant=0, o_stall_err=0, counter=0, preference=A.
REQ-027 Both o_busy_a and o_busy_b SHALL be high while i_reset is asserted.
REQ-028 Reset mid-packet SHALL discard the packet; no word SHALL emerge after release until a new grant.

Configuration
REQ-029 Macro EXARB_FIXED_PRIORITY_EN: when defined, A SHALL always win IDLE contention; when undefined, REQ-016 round-robin applies; OWN-state behaviour identical in both.

Structure
REQ-030 Shared package exbus_pkg SHALL hold EXWORD_W=35, the special-word code 2'b11, and the grant state enumeration.
REQ-031 No sub-module; one FSM plus one output register stage.

Verification
REQ-032 Idle, A sends 3 words 0x1,0x2,0x3(last) with i_busy=0 -> o_word 0x1,0x2,0x3 on consecutive cycles, o_last on 0x3, o_grant=01 throughout.
REQ-033 A and B both request in IDLE from reset, 2-word packets each -> A packet fully, then B packet, no interleave; repeat -> B first (A first with EXARB_FIXED_PRIORITY_EN).
REQ-034 i_busy held high 5 cycles mid-packet -> o_word stable, o_busy_a high, no word lost or duplicated.
REQ-035 A owns, drops i_stb_a for 2^LGSTALL cycles with B requesting -> o_stall_err one pulse, grant moves to B.
REQ-036 Special word 0x6_0000_0000 from B -> emerges bit-identical.
REQ-037 Reset asserted mid-packet on B -> outputs zero immediately, no residual B words after release.
